// File: rtl/rv_wb_pkg.sv
// rtl/rv_wb_pkg.sv - shared types and load encodings for the writeback stage
package rv_wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  addr;
    logic        we;
    logic [31:0] dat;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_ld_align.sv
// rtl/wb_stage_ld_align.sv - combinational load byte/half extraction and misalignment check
import rv_wb_pkg::*;

module ld_align (
  input  logic [31:0] raw,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = raw[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU: data = {24'b0, ld_byte};
      F3_LH: begin
        data = {{16{ld_half[15]}}, ld_half};
        err  = off[0];
      end
      F3_LHU: begin
        data = {16'b0, ld_half};
        err  = off[0];
      end
      F3_LW: begin
        data = raw;
        err  = (off != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - 2-entry writeback FIFO driving the register file write port
import rv_wb_pkg::*;

module wb_stage #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_rd_we,
  input  logic [1:0]      i_wb_sel,
  input  logic [XLEN-1:0] i_alu_res,
  input  logic [XLEN-1:0] i_pc4,
  input  logic [XLEN-1:0] i_ld_dat,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_off,
  input  logic            i_hold,
  output logic [4:0]      o_wr_addr,
  output logic            o_wr_en,
  output logic [XLEN-1:0] o_wr_dat,
  output logic            o_fwd_valid,
  output logic [4:0]      o_fwd_addr,
  output logic [XLEN-1:0] o_fwd_dat,
  output logic            o_ld_err,
  output logic [31:0]     o_retire_cnt
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  wb_entry_t   mem [DEPTH];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count, count_nxt;
  logic        ready_q;
  logic [31:0] retire_q;

  logic [31:0] ld_data, fmt_dat;
  logic        ld_err_raw, bad_ld, enq, deq, has_head;
  wb_entry_t   new_entry, head;

  ld_align u_ld_align (
    .raw    (i_ld_dat),
    .funct3 (i_ld_funct3),
    .off    (i_ld_off),
    .data   (ld_data),
    .err    (ld_err_raw)
  );

  // Reserved select 11 falls through to the ALU result.
  always_comb begin
    fmt_dat = i_alu_res;
    case (i_wb_sel)
      WB_LOAD: fmt_dat = ld_data;
      WB_PC4:  fmt_dat = i_pc4;
      default: fmt_dat = i_alu_res;
    endcase
  end

  assign bad_ld         = (i_wb_sel == WB_LOAD) && ld_err_raw;
  assign new_entry.addr = i_rd_addr;
  assign new_entry.we   = i_rd_we && !bad_ld;
  assign new_entry.dat  = bad_ld ? '0 : fmt_dat;

  assign has_head = (count != 2'd0);
  assign head     = mem[rd_ptr];
  assign enq      = i_valid && ready_q;
  assign deq      = has_head && !i_hold;

  always_comb begin
    count_nxt = count;
    case ({enq, deq})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // Ready is registered so it is low throughout reset and never depends on i_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      ready_q  <= 1'b0;
      o_ld_err <= 1'b0;
      retire_q <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (deq) begin
        rd_ptr   <= ~rd_ptr;
        retire_q <= retire_q + 32'd1;
      end
      count    <= count_nxt;
      ready_q  <= (count_nxt != FULL);
      o_ld_err <= enq && bad_ld;
    end
  end

  assign o_ready      = ready_q;
  assign o_retire_cnt = retire_q;
  assign o_wr_en      = deq && head.we && (head.addr != 5'd0);
  assign o_wr_addr    = has_head ? head.addr : 5'd0;
  assign o_wr_dat     = has_head ? head.dat : '0;
  assign o_fwd_valid  = has_head && head.we && (head.addr != 5'd0);
  assign o_fwd_addr   = o_wr_addr;
  assign o_fwd_dat    = o_wr_dat;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [4:0]  i_rd_addr;
  logic        i_rd_we;
  logic [1:0]  i_wb_sel;
  logic [31:0] i_alu_res, i_pc4, i_ld_dat;
  logic [2:0]  i_ld_funct3;
  logic [1:0]  i_ld_off;
  logic        i_hold;
  logic [4:0]  o_wr_addr;
  logic        o_wr_en;
  logic [31:0] o_wr_dat;
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_addr;
  logic [31:0] o_fwd_dat;
  logic        o_ld_err;
  logic [31:0] o_retire_cnt;

  wb_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_rd_addr(i_rd_addr), .i_rd_we(i_rd_we), .i_wb_sel(i_wb_sel),
    .i_alu_res(i_alu_res), .i_pc4(i_pc4), .i_ld_dat(i_ld_dat),
    .i_ld_funct3(i_ld_funct3), .i_ld_off(i_ld_off), .i_hold(i_hold),
    .o_wr_addr(o_wr_addr), .o_wr_en(o_wr_en), .o_wr_dat(o_wr_dat),
    .o_fwd_valid(o_fwd_valid), .o_fwd_addr(o_fwd_addr), .o_fwd_dat(o_fwd_dat),
    .o_ld_err(o_ld_err), .o_retire_cnt(o_retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  ld_err_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every committed write must match the next expected write, in order.
  always @(negedge clk) begin
    if (rst === 1'b1 && o_wr_en === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got x%0d=%h expected no write", o_wr_addr, o_wr_dat);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (o_wr_addr !== e.a || o_wr_dat !== e.d) begin
          n_fail++;
          $display("FAIL write_port: got x%0d=%h expected x%0d=%h", o_wr_addr, o_wr_dat, e.a, e.d);
        end
      end
    end
    if (rst === 1'b1 && o_ld_err === 1'b1) ld_err_pulses++;
  end

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] ld,
                       input logic [2:0] f3, input logic [1:0] off);
    i_rd_addr   = rd;
    i_rd_we     = we;
    i_wb_sel    = sel;
    i_alu_res   = alu;
    i_pc4       = pc4;
    i_ld_dat    = ld;
    i_ld_funct3 = f3;
    i_ld_off    = off;
    i_valid     = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic wait_accept();
    int   n;
    logic acc;
    n = 0;
    forever begin
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic send(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] ld,
                      input logic [2:0] f3, input logic [1:0] off);
    drive(rd, we, sel, alu, pc4, ld, f3, off);
    wait_accept();
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  localparam logic [31:0] LDW = 32'h80FF7F01;

  initial begin
    int r0, e0;
    rst = 1'b0;
    i_hold = 1'b0;
    drive(5'd0, 1'b0, 2'b00, '0, '0, '0, 3'b000, 2'b00);
    i_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_ready", {31'b0, o_ready}, 32'd0);
    check("reset_wr_en", {31'b0, o_wr_en}, 32'd0);
    check("reset_retire", o_retire_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    i_valid = 1'b0;
    tick(1);
    check("ready_after_reset", {31'b0, o_ready}, 32'd1);

    // ALU write, then PC+4 and the reserved select
    expect_wr(5'd5, 32'h12345678);
    send(5'd5, 1'b1, 2'b00, 32'h12345678, 32'h0, 32'h0, 3'b000, 2'b00);
    check("fwd_valid_alu", {31'b0, o_fwd_valid}, 32'd1);
    check("retire_before_commit", o_retire_cnt, 32'd0);
    tick(1);
    check("retire_after_commit", o_retire_cnt, 32'd1);
    expect_wr(5'd1, 32'h00001004);
    send(5'd1, 1'b1, 2'b10, 32'hDEADBEEF, 32'h00001004, 32'h0, 3'b000, 2'b00);
    expect_wr(5'd2, 32'hCAFEF00D);
    send(5'd2, 1'b1, 2'b11, 32'hCAFEF00D, 32'h00001004, 32'h0, 3'b000, 2'b00);

    // Load formatting
    expect_wr(5'd10, 32'hFFFFFF80);
    send(5'd10, 1'b1, 2'b01, 32'h0, 32'h0, LDW, 3'b000, 2'd3);
    expect_wr(5'd11, 32'h00000080);
    send(5'd11, 1'b1, 2'b01, 32'h0, 32'h0, LDW, 3'b100, 2'd3);
    expect_wr(5'd12, 32'hFFFF80FF);
    send(5'd12, 1'b1, 2'b01, 32'h0, 32'h0, LDW, 3'b001, 2'd2);
    expect_wr(5'd13, 32'h00007F01);
    send(5'd13, 1'b1, 2'b01, 32'h0, 32'h0, LDW, 3'b101, 2'd0);
    expect_wr(5'd14, 32'h80FF7F01);
    send(5'd14, 1'b1, 2'b01, 32'h0, 32'h0, LDW, 3'b010, 2'd0);
    tick(3);

    // Misaligned LH: error pulse, no write, still retires
    r0 = o_retire_cnt;
    e0 = ld_err_pulses;
    send(5'd7, 1'b1, 2'b01, 32'h0, 32'h0, LDW, 3'b001, 2'd1);
    check("ld_err_high", {31'b0, o_ld_err}, 32'd1);
    tick(3);
    check("ld_err_once", ld_err_pulses, e0 + 1);
    check("bad_ld_retires", o_retire_cnt, r0 + 1);

    // Backpressure under hold
    i_hold = 1'b1;
    expect_wr(5'd1, 32'h00000011);
    expect_wr(5'd2, 32'h00000022);
    expect_wr(5'd3, 32'h00000033);
    send(5'd1, 1'b1, 2'b00, 32'h11, 32'h0, 32'h0, 3'b000, 2'b00);
    send(5'd2, 1'b1, 2'b00, 32'h22, 32'h0, 32'h0, 3'b000, 2'b00);
    check("full_not_ready", {31'b0, o_ready}, 32'd0);
    drive(5'd3, 1'b1, 2'b00, 32'h33, 32'h0, 32'h0, 3'b000, 2'b00);
    tick(2);
    check("held_not_ready", {31'b0, o_ready}, 32'd0);
    check("hold_fwd_valid", {31'b0, o_fwd_valid}, 32'd1);
    check("hold_fwd_addr", {27'b0, o_fwd_addr}, 32'd1);
    check("hold_fwd_dat", o_fwd_dat, 32'h11);
    r0 = o_retire_cnt;
    i_hold = 1'b0;
    wait_accept();
    tick(1);
    check("drain_retire", o_retire_cnt, r0 + 3);

    // x0 destination
    r0 = o_retire_cnt;
    send(5'd0, 1'b1, 2'b00, 32'hFFFFFFFF, 32'h0, 32'h0, 3'b000, 2'b00);
    check("x0_wr_en", {31'b0, o_wr_en}, 32'd0);
    check("x0_fwd_valid", {31'b0, o_fwd_valid}, 32'd0);
    tick(1);
    check("x0_retires", o_retire_cnt, r0 + 1);

    // Retire counter wrap
    expect_wr(5'd9, 32'h99);
    send(5'd9, 1'b1, 2'b00, 32'h99, 32'h0, 32'h0, 3'b000, 2'b00);
    dut.retire_q = 32'hFFFFFFFF;
    tick(1);
    check("retire_wrap", o_retire_cnt, 32'h00000000);

    // Reset while entries are buffered
    i_hold = 1'b1;
    send(5'd4, 1'b1, 2'b00, 32'h44, 32'h0, 32'h0, 3'b000, 2'b00);
    send(5'd6, 1'b1, 2'b00, 32'h66, 32'h0, 32'h0, 3'b000, 2'b00);
    check("pre_reset_fwd", {31'b0, o_fwd_valid}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_reset_fwd", {31'b0, o_fwd_valid}, 32'd0);
    check("mid_reset_wr_addr", {27'b0, o_wr_addr}, 32'd0);
    check("mid_reset_ready", {31'b0, o_ready}, 32'd0);
    i_hold = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);
    check("post_reset_ready", {31'b0, o_ready}, 32'd1);
    check("post_reset_empty", {31'b0, o_fwd_valid}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage that sits directly upstream of reg_file. It accepts completed instructions from the memory stage over a valid/ready handshake and buffers them in a 2-entry FIFO. It formats load data (byte/half extraction with sign or zero extension), selects the result source, and drives reg_file's single write port. It also exposes a forwarding view of the head entry and a retired-instruction counter.

Parameters:
DEPTH, 2, FIFO entries; fixed at 2 (count fits in 2 bits); other values unsupported
XLEN, 32, data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-low; state cleared while rst==0
i_valid  in  1  upstream entry valid
o_ready  out  1  stage can accept; equals (count != 2); driven from registered state only
i_rd_addr  in  5  destination register
i_rd_we  in  1  instruction writes rd
i_wb_sel  in  2  result source: 00 ALU, 01 LOAD, 10 PC+4, 11 reserved (treated as ALU)
i_alu_res  in  32  ALU result
i_pc4  in  32  PC+4 for JAL/JALR
i_ld_dat  in  32  raw aligned load word
i_ld_funct3  in  3  load type
i_ld_off  in  2  byte offset within word
i_hold  in  1  debug halt; blocks dequeue
o_wr_addr  out  5  to reg_file i_wr_addr
o_wr_en  out  1  to reg_file i_wr_en
o_wr_dat  out  32  to reg_file i_wr_dat
o_fwd_valid  out  1  head entry present and will write a nonzero rd
o_fwd_addr  out  5  head rd
o_fwd_dat  out  32  head formatted result
o_ld_err  out  1  one-cycle pulse on enqueue of a bad load
o_retire_cnt  out  32  committed-instruction count

Behaviour:
- Reset values: count=0, pointers=0, o_wr_en=0, o_wr_addr=0, o_wr_dat=0, o_fwd_*=0, o_ld_err=0, o_retire_cnt=0, o_ready=1 after reset deassertion. Reset mid-operation drops all buffered entries immediately.
- Enqueue: when i_valid && o_ready at a rising edge. The formatted result is computed combinationally and stored, not raw inputs.
- Dequeue: when count>0 && !i_hold at a rising edge.
- Simultaneous enqueue and dequeue: count is unchanged and pointers both advance. At count==2, o_ready=0, so only a dequeue can occur. At count==0, no dequeue occurs.
- Write port: o_wr_en = (count>0) && !i_hold && head.we && (head.addr!=0). o_wr_addr and o_wr_dat always reflect the head entry, or 0 when empty.
- Commit timing: an entry accepted at edge N drives the write port during cycle N+1. reg_file captures it at edge N+1, giving one cycle of latency.
- x0 destination: the write is suppressed, but the entry still dequeues and retires.
- Load formatting (wb_sel=01):
  - 000 LB: sign-extended byte[off].
  - 100 LBU: zero-extended byte[off].
  - 001 LH: sign-extended half[off[1]].
  - 101 LHU: zero-extended half[off[1]].
  - 010 LW: full word.
- Bad load: LH/LHU with off[0]=1, LW with off!=0, or funct3 in {011,110,111}.
  - The entry is stored with we=0 and data 0.
  - o_ld_err pulses high for the cycle after the enqueue edge.
- Forwarding: o_fwd_* mirror the head entry regardless of i_hold. o_fwd_valid = (count>0) && head.we && head.addr!=0.
- Retire counter: increments by 1 on every dequeue and wraps 0xFFFFFFFF -> 0x00000000.
- Hold: freezes the head and o_wr_en=0. Enqueue continues until the FIFO is full.

Decomposition:
- Package rv_wb_pkg contains:
  - wb_sel_e enum (WB_ALU, WB_LOAD, WB_PC4).
  - Load funct3 localparams F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - wb_entry_t packed struct {addr, we, dat}.
- Sub-module ld_align: a purely combinational load formatter with inputs raw word, funct3, off and outputs data, err.
- The FIFO and counter stay in wb_stage.

Test Plan:
- Reset: rst=0 with i_valid=1 -> o_ready=0 during reset, o_wr_en=0, o_retire_cnt=0. After release, o_ready=1.
- ALU write, rd=5, alu_res=0x12345678: accept at edge N -> cycle N+1 shows o_wr_en=1, o_wr_addr=5, o_wr_dat=0x12345678. o_retire_cnt becomes 1 after edge N+1.
- Loads with ld_dat=0x80FF7F01:
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - LW off=0 -> 0x80FF7F01.
- Bad load, LH off=1: -> o_ld_err pulses once, o_wr_en stays 0, o_retire_cnt still increments.
- Backpressure: i_hold=1 with 3 back-to-back valids (rd=1,2,3) -> first two accepted, o_ready=0, third held. Release hold -> writes to x1, x2, x3 in consecutive cycles, in order.
- x0 and wrap:
  - Write to rd=0 with 0xFFFFFFFF -> o_wr_en=0, o_fwd_valid=0.
  - Force o_retire_cnt=0xFFFFFFFF (via a hierarchical deposit), then one dequeue -> 0x00000000.
